alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter P_WIDTH, default 16, which sets the operand and result width; legal values are 4 to 64.
REQ-002 SHALL have port I_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port I_RESET, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port I_VALID, input, 1 bit: the operation request.
REQ-005 SHALL have port I_OPCODE, input, 4 bits: the operation select.
REQ-006 SHALL have ports I_A and I_B, input, P_WIDTH bits each: the operands.
REQ-007 SHALL have port O_READY, output, 1 bit: the block can accept a request.
REQ-008 SHALL have port O_VALID, output, 1 bit: a one-cycle result strobe.
REQ-009 SHALL have port O_C, output, P_WIDTH bits: the primary result.
REQ-010 SHALL have port O_HI, output, P_WIDTH bits: the product high half or the division remainder, else 0.
REQ-011 SHALL have port O_STATUS, output, 5 bits, indexed [0] CARRY, [1] LOW, [2] FLAG, [3] ZERO, [4] NEGATIVE.

Function
REQ-012 SHALL accept a request on a rising edge where I_VALID and O_READY are both 1; the block ignores I_VALID when O_READY is 0.
REQ-013 SHALL implement opcodes 0 to 13 as single-cycle operations:
- ADD, ADDU, ADDC, ADDCU (the C variants add +1), AND, OR, XOR, NOT (~A), LSH, RSH, ALSH, ARSH shift I_A by I_B.
- SUB and SUBU compute I_B - I_A.
- O_C is wrapped modulo 2^P_WIDTH.
REQ-014 SHALL produce 0 from a shift when I_B >= P_WIDTH, except ARSH, which produces the sign fill of I_A.
REQ-015 SHALL set the status flags as follows; flags not listed are 0 and ZERO = (O_C == 0) for every opcode:
- ADD/ADDC: FLAG = signed overflow, NEGATIVE = O_C MSB.
- ADDU/ADDCU: CARRY = carry out.
- SUB: FLAG = signed overflow, NEGATIVE = signed I_B < I_A.
- SUBU: CARRY = LOW = (I_B <= I_A).
REQ-016 SHALL implement opcode 14 MUL as an unsigned iterative shift-add multiply: {O_HI, O_C} = I_A * I_B, CARRY = (O_HI != 0).
REQ-017 SHALL implement opcode 15 DIVU as unsigned restoring division: O_C = I_B / I_A, O_HI = I_B % I_A.
REQ-018 SHALL treat DIVU with I_A == 0 as single-cycle: O_C = all ones, O_HI = I_B, FLAG = 1.
REQ-019 SHALL register operands at acceptance, so later changes on I_A, I_B and I_OPCODE do not affect an operation in flight.
REQ-020 SHALL use states IDLE and BUSY:
- IDLE: O_READY = 1.
- IDLE -> BUSY on acceptance of MUL, or of DIVU with I_A != 0.
- BUSY: O_READY = 0; an iteration counter runs P_WIDTH cycles and the block returns to IDLE after the last iteration.
REQ-021 SHALL have latency, counted from the accept edge to the edge that raises O_VALID:
- 1 edge for single-cycle ops, with back-to-back accepts every cycle.
- P_WIDTH edges for MUL and DIVU.
- O_READY returns to 1 in the same cycle O_VALID is 1.
REQ-022 SHALL hold O_VALID high for exactly one cycle per accepted request.
REQ-023 SHALL hold O_C, O_HI and O_STATUS stable from one result until the next result.
REQ-024 SHALL use an iteration counter of $clog2(P_WIDTH+1) bits, and the counter shall never wrap.

Reset
REQ-025 SHALL, when I_RESET is 1 at an edge, clear O_VALID, O_C, O_HI and O_STATUS to 0, set the state to IDLE (O_READY = 1) and clear the counter.
REQ-026 SHALL abandon an in-flight MUL/DIVU on reset without producing O_VALID.
REQ-027 SHALL give reset priority over a simultaneous I_VALID.

Structure
REQ-028 SHALL take the opcode localparams (0 to 15) and the status bit indices from a shared package, cr16_alu_pkg, which the decoder also uses.
REQ-029 SHALL place the iterative multiply/divide datapath and its counter in one sub-module, alu_muldiv, with a start/done handshake; alu_mc owns the FSM and the output registers.

Verification (P_WIDTH = 16)
REQ-030 SHALL check ADD with A = 0x7FFF, B = 0x0001 -> next cycle O_VALID = 1, O_C = 0x8000, O_STATUS = 5'b10100.
REQ-031 SHALL check SUBU with A = 5, B = 3 back-to-back with XOR of A = B = 0x00FF -> consecutive cycles give 0xFFFE with status 5'b00011, then 0x0000 with status 5'b01000.
REQ-032 SHALL check MUL with A = 0x1234, B = 0x0100 -> O_READY = 0 for 15 cycles, O_VALID on edge 16, O_C = 0x3400, O_HI = 0x0012, CARRY = 1; an I_VALID pulse while busy is ignored.
REQ-033 SHALL check DIVU with B = 100, A = 7 -> after 16 edges O_C = 14, O_HI = 2. DIVU with A = 0, B = 9 -> after 1 edge O_C = 0xFFFF, O_HI = 9, FLAG = 1.
REQ-034 SHALL check I_RESET asserted on the 5th cycle of a MUL -> the next edge gives outputs 0 and O_READY = 1, and no O_VALID follows.

Source files
------------

// File: rtl/cr16_alu_pkg.sv
// Shared opcode map, status-bit positions and FSM state type for the
// multi-cycle ALU and its decoder.
package cr16_alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDU  = 4'd1;
  localparam logic [3:0] OP_ADDC  = 4'd2;
  localparam logic [3:0] OP_ADDCU = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_SUBU  = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_NOT   = 4'd9;
  localparam logic [3:0] OP_LSH   = 4'd10;
  localparam logic [3:0] OP_RSH   = 4'd11;
  localparam logic [3:0] OP_ALSH  = 4'd12;
  localparam logic [3:0] OP_ARSH  = 4'd13;
  localparam logic [3:0] OP_MUL   = 4'd14;
  localparam logic [3:0] OP_DIVU  = 4'd15;

  localparam int STATUS_W = 5;
  localparam int ST_CARRY = 0;
  localparam int ST_LOW   = 1;
  localparam int ST_FLAG  = 2;
  localparam int ST_ZERO  = 3;
  localparam int ST_NEG   = 4;

  typedef enum logic {IDLE, BUSY} alu_state_t;

  // Division by zero resolves immediately, so only a real divide iterates.
  function automatic logic is_multi_cycle(input logic [3:0] op, input logic a_zero);
    return (op == OP_MUL) || ((op == OP_DIVU) && !a_zero);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider sharing one
// accumulator/shift register pair and a single iteration counter.
module alu_muldiv
  import cr16_alu_pkg::*;
#(
  parameter int P_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_div,
  input  logic [P_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0] b,
  output logic               done,
  output logic [P_WIDTH-1:0] hi,
  output logic [P_WIDTH-1:0] lo
);

  localparam int CW = $clog2(P_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(P_WIDTH - 1);

  logic [CW-1:0]      cnt;
  logic               run;
  logic               run_div;
  logic [P_WIDTH-1:0] acc_q, sh_q, opd_q;
  logic               cur_div;
  logic [P_WIDTH-1:0] cur_acc, cur_sh, cur_opd;
  logic [P_WIDTH-1:0] nxt_acc, nxt_sh;
  logic [P_WIDTH:0]   sum, trial;

  // The start edge already performs the first iteration straight from the
  // operands, and the last one is taken combinationally, so the result is
  // ready on the P_WIDTH-th edge counted from acceptance.
  always_comb begin
    cur_div = run_div;
    cur_acc = acc_q;
    cur_sh  = sh_q;
    cur_opd = opd_q;
    if (start) begin
      cur_div = is_div;
      cur_acc = '0;
      cur_sh  = b;
      cur_opd = a;
    end
  end

  always_comb begin
    sum   = {1'b0, cur_acc} + (cur_sh[0] ? {1'b0, cur_opd} : '0);
    trial = {cur_acc, cur_sh[P_WIDTH-1]} - {1'b0, cur_opd};
    if (cur_div) begin
      if (!trial[P_WIDTH]) begin
        nxt_acc = trial[P_WIDTH-1:0];
        nxt_sh  = {cur_sh[P_WIDTH-2:0], 1'b1};
      end else begin
        nxt_acc = {cur_acc[P_WIDTH-2:0], cur_sh[P_WIDTH-1]};
        nxt_sh  = {cur_sh[P_WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_acc = sum[P_WIDTH:1];
      nxt_sh  = {sum[0], cur_sh[P_WIDTH-1:1]};
    end
  end

  assign done = run && (cnt == LAST);
  assign hi   = nxt_acc;
  assign lo   = nxt_sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      run     <= 1'b0;
      run_div <= 1'b0;
      cnt     <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opd_q   <= '0;
    end else if (start) begin
      run     <= 1'b1;
      run_div <= is_div;
      cnt     <= CW'(1);
      acc_q   <= nxt_acc;
      sh_q    <= nxt_sh;
      opd_q   <= a;
    end else if (run) begin
      acc_q <= nxt_acc;
      sh_q  <= nxt_sh;
      if (done) begin
        run <= 1'b0;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle decoder for opcodes 0-13, iterative MUL/DIVU
// through alu_muldiv, with registered results and a one-cycle valid strobe.
module alu_mc
  import cr16_alu_pkg::*;
#(
  parameter int P_WIDTH = 16
) (
  input  logic                I_CLK,
  input  logic                I_RESET,
  input  logic                I_VALID,
  input  logic [3:0]          I_OPCODE,
  input  logic [P_WIDTH-1:0]  I_A,
  input  logic [P_WIDTH-1:0]  I_B,
  output logic                O_READY,
  output logic                O_VALID,
  output logic [P_WIDTH-1:0]  O_C,
  output logic [P_WIDTH-1:0]  O_HI,
  output logic [STATUS_W-1:0] O_STATUS
);

  localparam int MSB = P_WIDTH - 1;
  localparam logic [P_WIDTH-1:0] SH_LIMIT = P_WIDTH'(P_WIDTH);

  alu_state_t          state, state_nxt;
  logic                accept, start, done, mc_div, cin, big_shift;
  logic [P_WIDTH-1:0]  md_hi, md_lo, sc_c, sc_hi;
  logic [STATUS_W-1:0] sc_st, md_st;
  logic [P_WIDTH:0]    add_sum, sub_diff;

  alu_muldiv #(.P_WIDTH(P_WIDTH)) u_muldiv (
    .clk    (I_CLK),
    .reset  (I_RESET),
    .start  (start),
    .is_div (I_OPCODE == OP_DIVU),
    .a      (I_A),
    .b      (I_B),
    .done   (done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_ff @(posedge I_CLK) begin
    if (I_RESET) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    O_READY = (state == IDLE);
    accept  = I_VALID && O_READY;
    start   = accept && is_multi_cycle(I_OPCODE, I_A == '0);
  end

  // Single-cycle decoder; SUB/SUBU compute B - A.
  always_comb begin
    cin       = (I_OPCODE == OP_ADDC) || (I_OPCODE == OP_ADDCU);
    add_sum   = {1'b0, I_A} + {1'b0, I_B} + {{P_WIDTH{1'b0}}, cin};
    sub_diff  = {1'b0, I_B} - {1'b0, I_A};
    big_shift = (I_B >= SH_LIMIT);
    sc_c      = '0;
    sc_hi     = '0;
    sc_st     = '0;
    case (I_OPCODE)
      OP_ADD, OP_ADDC: begin
        sc_c            = add_sum[MSB:0];
        sc_st[ST_FLAG]  = (I_A[MSB] == I_B[MSB]) && (add_sum[MSB] != I_A[MSB]);
        sc_st[ST_NEG]   = add_sum[MSB];
      end
      OP_ADDU, OP_ADDCU: begin
        sc_c            = add_sum[MSB:0];
        sc_st[ST_CARRY] = add_sum[P_WIDTH];
      end
      OP_SUB: begin
        sc_c            = sub_diff[MSB:0];
        sc_st[ST_FLAG]  = (I_A[MSB] != I_B[MSB]) && (sub_diff[MSB] != I_B[MSB]);
        sc_st[ST_NEG]   = $signed(I_B) < $signed(I_A);
      end
      OP_SUBU: begin
        sc_c            = sub_diff[MSB:0];
        sc_st[ST_CARRY] = (I_B <= I_A);
        sc_st[ST_LOW]   = (I_B <= I_A);
      end
      OP_AND: sc_c = I_A & I_B;
      OP_OR:  sc_c = I_A | I_B;
      OP_XOR: sc_c = I_A ^ I_B;
      OP_NOT: sc_c = ~I_A;
      OP_LSH, OP_ALSH: begin
        if (big_shift) sc_c = '0;
        else           sc_c = I_A << I_B;
      end
      OP_RSH: begin
        if (big_shift) sc_c = '0;
        else           sc_c = I_A >> I_B;
      end
      OP_ARSH: begin
        if (big_shift) sc_c = {P_WIDTH{I_A[MSB]}};
        else           sc_c = $signed(I_A) >>> I_B;
      end
      OP_DIVU: begin
        sc_c           = '1;
        sc_hi          = I_B;
        sc_st[ST_FLAG] = 1'b1;
      end
      default: ;
    endcase
    sc_st[ST_ZERO] = (sc_c == '0);
  end

  always_comb begin
    md_st           = '0;
    md_st[ST_ZERO]  = (md_lo == '0);
    md_st[ST_CARRY] = !mc_div && (md_hi != '0);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      O_VALID  <= 1'b0;
      O_C      <= '0;
      O_HI     <= '0;
      O_STATUS <= '0;
      mc_div   <= 1'b0;
    end else begin
      O_VALID <= 1'b0;
      if (start) mc_div <= (I_OPCODE == OP_DIVU);
      if (accept && !start) begin
        O_VALID  <= 1'b1;
        O_C      <= sc_c;
        O_HI     <= sc_hi;
        O_STATUS <= sc_st;
      end else if (done) begin
        O_VALID  <= 1'b1;
        O_C      <= md_lo;
        O_HI     <= md_hi;
        O_STATUS <= md_st;
      end
    end
  end

endmodule
